// File: rtl/sensor_node_pkg.sv
// Shared types and helpers for the sensor node hub.
// State encoding, default timeout and the unsigned distance helper.
package sensor_node_pkg;

  typedef enum logic {
    ACTIVE = 1'b0,
    SLEEP  = 1'b1
  } state_e;

  localparam int DEFAULT_SLEEP_TIMEOUT = 1000;

  // Operands are zero-extended by the caller, so the result never wraps.
  function automatic logic [31:0] abs_diff(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/idle_sleep_timer.sv
// Idle counter and sleep flag for the sensor node hub.
// Counts quiet cycles in ACTIVE; activity or wake returns to ACTIVE.
module idle_sleep_timer
  import sensor_node_pkg::*;
#(
  parameter int SLEEP_TIMEOUT = DEFAULT_SLEEP_TIMEOUT,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic activity,
  input  logic wake,
  output logic sleep
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLEEP_TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sleep_q;
  logic             busy;

  assign busy  = activity | wake;
  assign sleep = sleep_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
      sleep_q <= 1'b0;
    end else begin
      unique case (state_q)
        ACTIVE: begin
          if (busy) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= SLEEP;
            sleep_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SLEEP: begin
          if (busy) begin
            state_q <= ACTIVE;
            sleep_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ACTIVE;
          sleep_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sensor_node_hub.sv
// Report-on-change multi-channel sensor front end.
// One-entry output register, per-channel history, idle sleep control.
module sensor_node_hub
  import sensor_node_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CH        = 4,
  parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int SLEEP_TIMEOUT = DEFAULT_SLEEP_TIMEOUT,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [CH_W-1:0]       sample_ch,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  force_wake,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [CH_W-1:0]       tx_ch,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  sleep,
  output logic [CNT_W-1:0]      drop_count
);

  localparam int          DEPTH    = 2 ** CH_W;
  localparam logic [31:0] NUM_CH_U = NUM_CH;

  logic [DATA_WIDTH-1:0] last_q [DEPTH];

  logic                  tx_valid_q, tx_valid_d;
  logic [CH_W-1:0]       tx_ch_q, tx_ch_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]      drop_q, drop_d;

  logic        ch_ok;
  logic [31:0] diff;
  logic        reportable;
  logic        reg_free;
  logic        accept;
  logic        dropped;

  assign ch_ok = 32'(sample_ch) < NUM_CH_U;
  assign diff  = abs_diff(32'(sample_data), 32'(last_q[sample_ch]));

  assign reportable = sample_valid & ch_ok & (diff >= 32'(threshold));
  assign reg_free   = ~tx_valid_q | tx_ready;
  assign accept     = reportable & reg_free;
  assign dropped    = reportable & ~reg_free;

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_ch_d    = tx_ch_q;
    tx_data_d  = tx_data_q;
    drop_d     = drop_q;
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_ch_d    = sample_ch;
      tx_data_d  = sample_data;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end
    if (dropped && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid_q <= 1'b0;
      tx_ch_q    <= '0;
      tx_data_q  <= '0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        last_q[i] <= '0;
      end
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_ch_q    <= tx_ch_d;
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
      if (accept) begin
        last_q[sample_ch] <= sample_data;
      end
    end
  end

  // A pending word counts as activity so sleep never strands it.
  idle_sleep_timer #(
    .SLEEP_TIMEOUT(SLEEP_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .activity(reportable | tx_valid_q),
    .wake    (force_wake),
    .sleep   (sleep)
  );

  assign tx_valid   = tx_valid_q;
  assign tx_ch      = tx_ch_q;
  assign tx_data    = tx_data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_sensor_node_hub.sv
// Directed self-checking bench for sensor_node_hub.
// Vector table for the datapath, hand sequences for sleep and reset.
module tb_sensor_node_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [7:0]  sample_data;
  logic [7:0]  threshold;
  logic        force_wake;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  tx_ch;
  logic [7:0]  tx_data;
  logic        sleep;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sensor_node_hub #(
    .DATA_WIDTH   (8),
    .NUM_CH       (4),
    .SLEEP_TIMEOUT(8),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_ch   (sample_ch),
    .sample_data (sample_data),
    .threshold   (threshold),
    .force_wake  (force_wake),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_ch       (tx_ch),
    .tx_data     (tx_data),
    .sleep       (sleep),
    .drop_count  (drop_count)
  );

  typedef struct {
    logic        v;
    logic [1:0]  ch;
    logic [7:0]  d;
    logic [7:0]  thr;
    logic        rdy;
    logic        txv;
    logic [1:0]  tch;
    logic [7:0]  tdat;
    logic [15:0] drop;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic v, input logic [1:0] ch, input logic [7:0] d,
    input logic [7:0] thr, input logic rdy, input logic txv,
    input logic [1:0] tch, input logic [7:0] tdat,
    input logic [15:0] drop
  );
    vec_t r;
    r.v = v; r.ch = ch; r.d = d; r.thr = thr; r.rdy = rdy;
    r.txv = txv; r.tch = tch; r.tdat = tdat; r.drop = drop;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    sample_valid = 1'b0;
    sample_ch    = 2'd0;
    sample_data  = 8'h00;
    force_wake   = 1'b0;
  endtask

  task automatic put(input logic [1:0] ch, input logic [7:0] d);
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_data  = d;
  endtask

  initial begin
    tbl[0]  = mk(1, 2'd1, 8'h20, 8'h10, 1, 1, 2'd1, 8'h20, 16'd0);
    tbl[1]  = mk(1, 2'd1, 8'h28, 8'h10, 1, 0, 2'd0, 8'h00, 16'd0);
    tbl[2]  = mk(1, 2'd2, 8'h80, 8'h10, 1, 1, 2'd2, 8'h80, 16'd0);
    tbl[3]  = mk(1, 2'd2, 8'h6F, 8'h10, 1, 1, 2'd2, 8'h6F, 16'd0);
    tbl[4]  = mk(1, 2'd3, 8'hFF, 8'hFF, 1, 1, 2'd3, 8'hFF, 16'd0);
    tbl[5]  = mk(1, 2'd3, 8'h00, 8'hFF, 1, 1, 2'd3, 8'h00, 16'd0);
    tbl[6]  = mk(1, 2'd0, 8'h0F, 8'h10, 1, 0, 2'd0, 8'h00, 16'd0);
    tbl[7]  = mk(1, 2'd0, 8'h00, 8'h00, 1, 1, 2'd0, 8'h00, 16'd0);
    tbl[8]  = mk(0, 2'd0, 8'h00, 8'h10, 1, 0, 2'd0, 8'h00, 16'd0);
    tbl[9]  = mk(1, 2'd0, 8'h40, 8'h10, 0, 1, 2'd0, 8'h40, 16'd0);
    tbl[10] = mk(1, 2'd3, 8'h50, 8'h10, 0, 1, 2'd0, 8'h40, 16'd1);
    tbl[11] = mk(0, 2'd0, 8'h00, 8'h10, 0, 1, 2'd0, 8'h40, 16'd1);
    tbl[12] = mk(0, 2'd0, 8'h00, 8'h10, 1, 0, 2'd0, 8'h00, 16'd1);
    tbl[13] = mk(1, 2'd3, 8'h50, 8'h10, 1, 1, 2'd3, 8'h50, 16'd1);
    tbl[14] = mk(0, 2'd0, 8'h00, 8'h10, 1, 0, 2'd0, 8'h00, 16'd1);

    reset     = 1'b1;
    threshold = 8'h10;
    tx_ready  = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_ch", 32'(tx_ch), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_sleep", 32'(sleep), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      sample_valid = tbl[i].v;
      sample_ch    = tbl[i].ch;
      sample_data  = tbl[i].d;
      threshold    = tbl[i].thr;
      tx_ready     = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_txv", i), 32'(tx_valid), 32'(tbl[i].txv));
      if (tbl[i].txv) begin
        chk($sformatf("vec%0d_ch", i), 32'(tx_ch), 32'(tbl[i].tch));
        chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(tbl[i].tdat));
      end
      chk($sformatf("vec%0d_sleep", i), 32'(sleep), 32'd0);
      chk($sformatf("vec%0d_drop", i), 32'(drop_count), 32'(tbl[i].drop));
    end

    // Quiet from here: sleep exactly on the 8th edge.
    idle_in();
    threshold = 8'h10;
    tx_ready  = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("to_early%0d", i), 32'(sleep), 32'd0);
    end
    tick();
    chk("to_sleep", 32'(sleep), 32'd1);

    put(2'd0, 8'h45);
    tick();
    chk("nonrep_sleep", 32'(sleep), 32'd1);
    chk("nonrep_txv", 32'(tx_valid), 32'd0);

    put(2'd0, 8'h80);
    tick();
    chk("wake_sleep", 32'(sleep), 32'd0);
    chk("wake_txv", 32'(tx_valid), 32'd1);
    chk("wake_ch", 32'(tx_ch), 32'd0);
    chk("wake_data", 32'(tx_data), 32'h80);

    idle_in();
    tick();
    chk("wake_hs", 32'(tx_valid), 32'd0);
    repeat (7) tick();
    chk("sleep2_early", 32'(sleep), 32'd0);
    tick();
    chk("sleep2", 32'(sleep), 32'd1);

    force_wake = 1'b1;
    tick();
    force_wake = 1'b0;
    chk("fw_sleep", 32'(sleep), 32'd0);
    chk("fw_txv", 32'(tx_valid), 32'd0);
    repeat (7) tick();
    chk("fw_restart_early", 32'(sleep), 32'd0);
    tick();
    chk("fw_restart_sleep", 32'(sleep), 32'd1);

    // Wake, then land a reportable sample on the timeout cycle.
    force_wake = 1'b1;
    tick();
    force_wake = 1'b0;
    chk("fw2_sleep", 32'(sleep), 32'd0);
    repeat (7) tick();
    chk("coinc_pre", 32'(sleep), 32'd0);
    put(2'd1, 8'h90);
    tick();
    chk("coinc_sleep", 32'(sleep), 32'd0);
    chk("coinc_txv", 32'(tx_valid), 32'd1);
    chk("coinc_ch", 32'(tx_ch), 32'd1);
    chk("coinc_data", 32'(tx_data), 32'h90);

    idle_in();
    tx_ready = 1'b0;
    tick();
    chk("hold_txv", 32'(tx_valid), 32'd1);
    chk("hold_data", 32'(tx_data), 32'h90);
    chk("hold_drop", 32'(drop_count), 32'd1);

    #2;
    reset = 1'b1;
    #1;
    chk("async_txv", 32'(tx_valid), 32'd0);
    chk("async_sleep", 32'(sleep), 32'd0);
    chk("async_drop", 32'(drop_count), 32'd0);
    tick();
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
